// File: rtl/reservation_station_param.sv
// reservation_station_param: DEPTH-entry reservation station for one functional unit.
// Operations are captured from issue/rename, woken up by CDB broadcasts that match
// their ROB tags, and handed to the FU oldest-ready-first through a registered
// output stage. Optional feature macro: RS_FLUSH_EN adds the flush_in port and
// the squash logic. Without it the port does not exist.
//
// Handshakes:
//   Issue side    : an insert is accepted at a rising edge where
//                   valid_input_in && rs_free_for_input_out. There is no wait state;
//                   a request made while full is dropped.
//   Dispatch side : rs_output_valid_out is registered. A dispatch completes at a
//                   rising edge where rs_output_valid_out && fu_ready_in. While
//                   rs_output_valid_out && !fu_ready_in, all outputs hold stable.
module reservation_station_param #(
  parameter int DEPTH    = 4,
  parameter int ROB_IX_W = 3,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         valid_input_in,
  output logic                         rs_free_for_input_out,
  input  logic [ROB_IX_W-1:0]          Q_i_in,
  input  logic [ROB_IX_W-1:0]          Q_j_in,
  input  logic [DATA_W-1:0]            V_i_in,
  input  logic [DATA_W-1:0]            V_j_in,
  input  logic                         i_ready_in,
  input  logic                         j_ready_in,
  input  logic [ROB_IX_W-1:0]          rob_ix_in,
  input  logic [OP_W-1:0]              opcode_in,
  input  logic                         cdb_valid_in,
  input  logic [ROB_IX_W-1:0]          cdb_rob_ix_in,
  input  logic [DATA_W-1:0]            cdb_value_in,
  input  logic                         fu_ready_in,
`ifdef RS_FLUSH_EN
  input  logic                         flush_in,
`endif
  output logic                         rs_output_valid_out,
  output logic [DATA_W-1:0]            rval1_out,
  output logic [DATA_W-1:0]            rval2_out,
  output logic [OP_W-1:0]              opcode_out,
  output logic [ROB_IX_W-1:0]          rob_ix_out,
  output logic [$clog2(DEPTH+1)-1:0]   free_count_out
);

  localparam int AGE_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Entry storage. age counts the busy entries inserted after this one, so the
  // oldest busy entry always holds the largest age and ages stay unique.
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DEPTH-1:0]    i_rdy_q, i_rdy_d;
  logic [DEPTH-1:0]    j_rdy_q, j_rdy_d;
  logic [ROB_IX_W-1:0] q_i_q [DEPTH];
  logic [ROB_IX_W-1:0] q_i_d [DEPTH];
  logic [ROB_IX_W-1:0] q_j_q [DEPTH];
  logic [ROB_IX_W-1:0] q_j_d [DEPTH];
  logic [DATA_W-1:0]   v_i_q [DEPTH];
  logic [DATA_W-1:0]   v_i_d [DEPTH];
  logic [DATA_W-1:0]   v_j_q [DEPTH];
  logic [DATA_W-1:0]   v_j_d [DEPTH];
  logic [ROB_IX_W-1:0] rob_q [DEPTH];
  logic [ROB_IX_W-1:0] rob_d [DEPTH];
  logic [OP_W-1:0]     op_q  [DEPTH];
  logic [OP_W-1:0]     op_d  [DEPTH];
  logic [AGE_W-1:0]    age_q [DEPTH];
  logic [AGE_W-1:0]    age_d [DEPTH];

  // Registered dispatch stage.
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   rval1_q, rval1_d;
  logic [DATA_W-1:0]   rval2_q, rval2_d;
  logic [OP_W-1:0]     op_out_q, op_out_d;
  logic [ROB_IX_W-1:0] rob_out_q, rob_out_d;

  // Combinational helpers.
  logic                ins_found;
  logic [AGE_W-1:0]    ins_idx;
  logic [CNT_W-1:0]    free_cnt;
  logic                sel_found;
  logic [AGE_W-1:0]    sel_idx;
  logic [AGE_W-1:0]    sel_age;
  logic                do_ins;
  logic                do_load;
  logic                flush_w;

`ifdef RS_FLUSH_EN
  assign flush_w = flush_in;
`else
  assign flush_w = 1'b0;
`endif

  // Find the lowest-index free entry and count free entries from current busy bits.
  always_comb begin
    ins_found = 1'b0;
    ins_idx   = '0;
    free_cnt  = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (!busy_q[e]) begin
        ins_found = 1'b1;
        ins_idx   = AGE_W'(e);
        free_cnt  = free_cnt + CNT_W'(1);
      end
    end
  end

  // Pick the oldest busy entry whose operands are both ready.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (busy_q[e] && i_rdy_q[e] && j_rdy_q[e] && (!sel_found || age_q[e] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = AGE_W'(e);
        sel_age   = age_q[e];
      end
    end
  end

  assign do_ins  = valid_input_in && ins_found;
  assign do_load = (!out_valid_q || fu_ready_in) && sel_found;

  // Next state of the entry array: wakeup, aging, dispatch free, insert, flush.
  always_comb begin
    int a;
    a       = 0;
    busy_d  = busy_q;
    i_rdy_d = i_rdy_q;
    j_rdy_d = j_rdy_q;
    q_i_d   = q_i_q;
    q_j_d   = q_j_q;
    v_i_d   = v_i_q;
    v_j_d   = v_j_q;
    rob_d   = rob_q;
    op_d    = op_q;
    age_d   = age_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (busy_q[e]) begin
        if (cdb_valid_in && !i_rdy_q[e] && (q_i_q[e] == cdb_rob_ix_in)) begin
          v_i_d[e]   = cdb_value_in;
          i_rdy_d[e] = 1'b1;
        end
        if (cdb_valid_in && !j_rdy_q[e] && (q_j_q[e] == cdb_rob_ix_in)) begin
          v_j_d[e]   = cdb_value_in;
          j_rdy_d[e] = 1'b1;
        end
        // Older entries lose one younger neighbour when a younger entry leaves,
        // and gain one on every insert.
        a = int'(age_q[e]);
        if (do_load && (age_q[e] > sel_age)) a = a - 1;
        if (do_ins) a = a + 1;
        if (a > DEPTH - 1) a = DEPTH - 1;
        age_d[e] = AGE_W'(a);
      end
      if (do_load && (e == int'(sel_idx))) begin
        busy_d[e]  = 1'b0;
        i_rdy_d[e] = 1'b0;
        j_rdy_d[e] = 1'b0;
        age_d[e]   = '0;
      end
      if (do_ins && (e == int'(ins_idx))) begin
        busy_d[e]  = 1'b1;
        q_i_d[e]   = Q_i_in;
        q_j_d[e]   = Q_j_in;
        v_i_d[e]   = V_i_in;
        v_j_d[e]   = V_j_in;
        i_rdy_d[e] = i_ready_in;
        j_rdy_d[e] = j_ready_in;
        rob_d[e]   = rob_ix_in;
        op_d[e]    = opcode_in;
        age_d[e]   = '0;
        // A broadcast in the insert cycle would otherwise be missed.
        if (cdb_valid_in && !i_ready_in && (Q_i_in == cdb_rob_ix_in)) begin
          v_i_d[e]   = cdb_value_in;
          i_rdy_d[e] = 1'b1;
        end
        if (cdb_valid_in && !j_ready_in && (Q_j_in == cdb_rob_ix_in)) begin
          v_j_d[e]   = cdb_value_in;
          j_rdy_d[e] = 1'b1;
        end
      end
      if (flush_w) begin
        busy_d[e]  = 1'b0;
        i_rdy_d[e] = 1'b0;
        j_rdy_d[e] = 1'b0;
        age_d[e]   = '0;
      end
    end
  end

  // Output stage: load from the selected entry, drop valid when drained, hold when stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    rval1_d     = rval1_q;
    rval2_d     = rval2_q;
    op_out_d    = op_out_q;
    rob_out_d   = rob_out_q;
    if (do_load) begin
      out_valid_d = 1'b1;
      rval1_d     = v_i_q[sel_idx];
      rval2_d     = v_j_q[sel_idx];
      op_out_d    = op_q[sel_idx];
      rob_out_d   = rob_q[sel_idx];
    end else if (fu_ready_in) begin
      out_valid_d = 1'b0;
    end
    if (flush_w) out_valid_d = 1'b0;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      i_rdy_q     <= '0;
      j_rdy_q     <= '0;
      out_valid_q <= 1'b0;
      rval1_q     <= '0;
      rval2_q     <= '0;
      op_out_q    <= '0;
      rob_out_q   <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        q_i_q[e] <= '0;
        q_j_q[e] <= '0;
        v_i_q[e] <= '0;
        v_j_q[e] <= '0;
        rob_q[e] <= '0;
        op_q[e]  <= '0;
        age_q[e] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      i_rdy_q     <= i_rdy_d;
      j_rdy_q     <= j_rdy_d;
      out_valid_q <= out_valid_d;
      rval1_q     <= rval1_d;
      rval2_q     <= rval2_d;
      op_out_q    <= op_out_d;
      rob_out_q   <= rob_out_d;
      for (int e = 0; e < DEPTH; e++) begin
        q_i_q[e] <= q_i_d[e];
        q_j_q[e] <= q_j_d[e];
        v_i_q[e] <= v_i_d[e];
        v_j_q[e] <= v_j_d[e];
        rob_q[e] <= rob_d[e];
        op_q[e]  <= op_d[e];
        age_q[e] <= age_d[e];
      end
    end
  end

  assign rs_free_for_input_out = ins_found;
  assign free_count_out        = free_cnt;
  assign rs_output_valid_out   = out_valid_q;
  assign rval1_out             = rval1_q;
  assign rval2_out             = rval2_q;
  assign opcode_out            = op_out_q;
  assign rob_ix_out            = rob_out_q;

endmodule

// File: tb/tb_reservation_station_param.sv
// tb_reservation_station_param: directed and random stimulus for the reservation
// station, checked against a queue-based model that keeps entries in insertion
// order and dispatches the first ready one.
module tb_reservation_station_param;

  localparam int DEPTH = 4;
  localparam int RW    = 3;
  localparam int DW    = 32;
  localparam int OW    = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int VEC_W = 1 + DW + DW + OW + RW + CW + 1;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  logic          valid_input_in;
  logic          rs_free_for_input_out;
  logic [RW-1:0] Q_i_in, Q_j_in;
  logic [DW-1:0] V_i_in, V_j_in;
  logic          i_ready_in, j_ready_in;
  logic [RW-1:0] rob_ix_in;
  logic [OW-1:0] opcode_in;
  logic          cdb_valid_in;
  logic [RW-1:0] cdb_rob_ix_in;
  logic [DW-1:0] cdb_value_in;
  logic          fu_ready_in;
`ifdef RS_FLUSH_EN
  logic          flush_in;
`endif
  logic          rs_output_valid_out;
  logic [DW-1:0] rval1_out, rval2_out;
  logic [OW-1:0] opcode_out;
  logic [RW-1:0] rob_ix_out;
  logic [CW-1:0] free_count_out;

  reservation_station_param #(
    .DEPTH(DEPTH), .ROB_IX_W(RW), .DATA_W(DW), .OP_W(OW)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .valid_input_in(valid_input_in),
    .rs_free_for_input_out(rs_free_for_input_out),
    .Q_i_in(Q_i_in),
    .Q_j_in(Q_j_in),
    .V_i_in(V_i_in),
    .V_j_in(V_j_in),
    .i_ready_in(i_ready_in),
    .j_ready_in(j_ready_in),
    .rob_ix_in(rob_ix_in),
    .opcode_in(opcode_in),
    .cdb_valid_in(cdb_valid_in),
    .cdb_rob_ix_in(cdb_rob_ix_in),
    .cdb_value_in(cdb_value_in),
    .fu_ready_in(fu_ready_in),
`ifdef RS_FLUSH_EN
    .flush_in(flush_in),
`endif
    .rs_output_valid_out(rs_output_valid_out),
    .rval1_out(rval1_out),
    .rval2_out(rval2_out),
    .opcode_out(opcode_out),
    .rob_ix_out(rob_ix_out),
    .free_count_out(free_count_out)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [RW-1:0] qi;
    logic [RW-1:0] qj;
    logic [DW-1:0] vi;
    logic [DW-1:0] vj;
    logic          ri;
    logic          rj;
    logic [RW-1:0] rob;
    logic [OW-1:0] op;
  } ent_t;

  ent_t          m_q[$];
  logic          m_valid;
  logic [DW-1:0] m_r1, m_r2;
  logic [OW-1:0] m_op;
  logic [RW-1:0] m_rob;

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_r1 = '0; m_r2 = '0; m_op = '0; m_rob = '0;
  endtask

  // One clock edge worth of behaviour, using the inputs present at the edge.
  task automatic model_step();
    int   sel;
    int   sz;
    ent_t t;
    sz  = m_q.size();
    sel = -1;
    for (int k = 0; k < sz; k++) if (sel < 0 && m_q[k].ri && m_q[k].rj) sel = k;
`ifdef RS_FLUSH_EN
    if (flush_in) begin
      m_q.delete();
      m_valid = 1'b0;
      return;
    end
`endif
    if ((!m_valid || fu_ready_in) && sel >= 0) begin
      t = m_q[sel];
      m_valid = 1'b1; m_r1 = t.vi; m_r2 = t.vj; m_op = t.op; m_rob = t.rob;
      m_q.delete(sel);
    end else if (fu_ready_in) begin
      m_valid = 1'b0;
    end
    for (int k = 0; k < m_q.size(); k++) begin
      t = m_q[k];
      if (cdb_valid_in && !t.ri && t.qi == cdb_rob_ix_in) begin t.vi = cdb_value_in; t.ri = 1'b1; end
      if (cdb_valid_in && !t.rj && t.qj == cdb_rob_ix_in) begin t.vj = cdb_value_in; t.rj = 1'b1; end
      m_q[k] = t;
    end
    if (valid_input_in && sz < DEPTH) begin
      t.qi = Q_i_in; t.qj = Q_j_in; t.vi = V_i_in; t.vj = V_j_in;
      t.ri = i_ready_in; t.rj = j_ready_in; t.rob = rob_ix_in; t.op = opcode_in;
      if (cdb_valid_in && !t.ri && t.qi == cdb_rob_ix_in) begin t.vi = cdb_value_in; t.ri = 1'b1; end
      if (cdb_valid_in && !t.rj && t.qj == cdb_rob_ix_in) begin t.vj = cdb_value_in; t.rj = 1'b1; end
      m_q.push_back(t);
    end
  endtask

  function automatic logic [VEC_W-1:0] exp_vec();
    return {m_valid, m_r1, m_r2, m_op, m_rob, CW'(DEPTH - m_q.size()), (m_q.size() < DEPTH)};
  endfunction

  logic [VEC_W-1:0] got_vec;
  assign got_vec = {rs_output_valid_out, rval1_out, rval2_out, opcode_out, rob_ix_out,
                    free_count_out, rs_free_for_input_out};

  // Scoreboard of expected dispatch order (ROB tags).
  logic [RW-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    valid_input_in = 1'b0;
    Q_i_in = '0; Q_j_in = '0; V_i_in = '0; V_j_in = '0;
    i_ready_in = 1'b0; j_ready_in = 1'b0; rob_ix_in = '0; opcode_in = '0;
    cdb_valid_in = 1'b0; cdb_rob_ix_in = '0; cdb_value_in = '0;
`ifdef RS_FLUSH_EN
    flush_in = 1'b0;
`endif
  endtask

  task automatic drive_insert(input logic [RW-1:0] rob, input logic [OW-1:0] op,
                              input logic [DW-1:0] vi, input logic ri, input logic [RW-1:0] qi,
                              input logic [DW-1:0] vj, input logic rj, input logic [RW-1:0] qj);
    valid_input_in = 1'b1;
    rob_ix_in = rob; opcode_in = op;
    V_i_in = vi; i_ready_in = ri; Q_i_in = qi;
    V_j_in = vj; j_ready_in = rj; Q_j_in = qj;
  endtask

  task automatic drive_cdb(input logic [RW-1:0] tag, input logic [DW-1:0] val);
    cdb_valid_in = 1'b1; cdb_rob_ix_in = tag; cdb_value_in = val;
  endtask

  task automatic drain();
    drive_idle();
    fu_ready_in = 1'b1;
    repeat (3) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    drive_idle();
    fu_ready_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_cnt++;
    if (got_vec !== {1'b0, {DW{1'b0}}, {DW{1'b0}}, {OW{1'b0}}, {RW{1'b0}}, CW'(DEPTH), 1'b1})
      $display("FAIL reset_state got=%h exp_valid=0 data=0 free=%0d rs_free=1", got_vec, DEPTH);
    else pass_cnt++;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_single();
    fu_ready_in = 1'b1;
    drive_insert(3'd2, 4'd1, 32'd5, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0);
    tick();
    drive_idle();
    check_cnt++;
    if (rs_output_valid_out !== 1'b0 || free_count_out !== CW'(DEPTH - 1))
      $display("FAIL single_insert_cycle got valid=%b free=%0d exp valid=0 free=%0d",
               rs_output_valid_out, free_count_out, DEPTH - 1);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (rs_output_valid_out !== 1'b1 || rval1_out !== 32'd5 || rval2_out !== 32'd7 ||
        rob_ix_out !== 3'd2 || opcode_out !== 4'd1 || free_count_out !== CW'(DEPTH))
      $display("FAIL single_dispatch got v=%b r1=%0d r2=%0d rob=%0d op=%0d free=%0d exp 1 5 7 2 1 %0d",
               rs_output_valid_out, rval1_out, rval2_out, rob_ix_out, opcode_out, free_count_out, DEPTH);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_wakeup_order();
    fu_ready_in = 1'b1;
    drive_insert(3'd1, 4'd3, 32'd1, 1'b1, 3'd0, 32'd0, 1'b0, 3'd5);
    tick();
    drive_insert(3'd2, 4'd4, 32'd2, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0);
    tick();
    drive_idle();
    tick();
    check_cnt++;
    if (rs_output_valid_out !== 1'b1 || rob_ix_out !== 3'd2)
      $display("FAIL ready_first got v=%b rob=%0d exp v=1 rob=2", rs_output_valid_out, rob_ix_out);
    else pass_cnt++;
    drive_cdb(3'd5, 32'h10);
    tick();
    drive_idle();
    tick();
    check_cnt++;
    if (rs_output_valid_out !== 1'b1 || rob_ix_out !== 3'd1 || rval2_out !== 32'h10 || rval1_out !== 32'd1)
      $display("FAIL wakeup_dispatch got v=%b rob=%0d r1=%h r2=%h exp v=1 rob=1 r1=1 r2=10",
               rs_output_valid_out, rob_ix_out, rval1_out, rval2_out);
    else pass_cnt++;
    check_cnt++;
    if (got_vec !== exp_vec()) $display("FAIL wakeup_model got=%h exp=%h", got_vec, exp_vec());
    else pass_cnt++;
    drain();
  endtask

  task automatic test_bypass();
    fu_ready_in = 1'b1;
    drive_insert(3'd3, 4'd2, 32'd0, 1'b0, 3'd3, 32'd4, 1'b1, 3'd0);
    drive_cdb(3'd3, 32'd9);
    tick();
    drive_idle();
    tick();
    check_cnt++;
    if (rs_output_valid_out !== 1'b1 || rob_ix_out !== 3'd3 || rval1_out !== 32'd9 || rval2_out !== 32'd4)
      $display("FAIL insert_bypass got v=%b rob=%0d r1=%0d r2=%0d exp v=1 rob=3 r1=9 r2=4",
               rs_output_valid_out, rob_ix_out, rval1_out, rval2_out);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    logic [VEC_W-1:0] snap;
    fu_ready_in = 1'b0;
    drive_insert(3'd1, 4'd5, 32'd1, 1'b1, 3'd0, 32'd2, 1'b1, 3'd0);
    tick();
    drive_insert(3'd2, 4'd6, 32'd3, 1'b1, 3'd0, 32'd4, 1'b1, 3'd0);
    tick();
    drive_idle();
    snap = got_vec;
    check_cnt++;
    if (rs_output_valid_out !== 1'b1 || rob_ix_out !== 3'd1)
      $display("FAIL stall_first got v=%b rob=%0d exp v=1 rob=1", rs_output_valid_out, rob_ix_out);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_cnt++;
      if (got_vec !== snap || got_vec !== exp_vec())
        $display("FAIL stall_hold cycle=%0d got=%h exp=%h", c, got_vec, exp_vec());
      else pass_cnt++;
    end
    fu_ready_in = 1'b1;
    tick();
    check_cnt++;
    if (rs_output_valid_out !== 1'b1 || rob_ix_out !== 3'd2 || rval1_out !== 32'd3 || rval2_out !== 32'd4)
      $display("FAIL stall_release got v=%b rob=%0d r1=%0d r2=%0d exp v=1 rob=2 r1=3 r2=4",
               rs_output_valid_out, rob_ix_out, rval1_out, rval2_out);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (rs_output_valid_out !== 1'b0) $display("FAIL stall_empty got v=%b exp v=0", rs_output_valid_out);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_full_order();
    int budget;
    fu_ready_in = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k % 2 == 0) drive_insert(RW'(k + 1), OW'(k), 32'd0, 1'b0, 3'd6, DW'(k + 8'h20), 1'b1, 3'd0);
      else            drive_insert(RW'(k + 1), OW'(k), DW'(k + 8'h20), 1'b1, 3'd0, 32'd0, 1'b0, 3'd6);
      tick();
    end
    check_cnt++;
    if (rs_free_for_input_out !== 1'b0 || free_count_out !== CW'(0) || rs_output_valid_out !== 1'b0)
      $display("FAIL full_flags got rs_free=%b free=%0d v=%b exp 0 0 0",
               rs_free_for_input_out, free_count_out, rs_output_valid_out);
    else pass_cnt++;
    drive_insert(3'd5, 4'd9, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    tick();
    check_cnt++;
    if (free_count_out !== CW'(0) || rs_output_valid_out !== 1'b0)
      $display("FAIL full_drop got free=%0d v=%b exp free=0 v=0", free_count_out, rs_output_valid_out);
    else pass_cnt++;
    drive_idle();
    drive_cdb(3'd6, 32'h66);
    tick();
    drive_idle();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(RW'(k + 1));
    budget = 12;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
      check_cnt++;
      if (got_vec !== exp_vec()) $display("FAIL full_model got=%h exp=%h", got_vec, exp_vec());
      else pass_cnt++;
      if (rs_output_valid_out === 1'b1) begin
        check_cnt++;
        if (rob_ix_out !== exp_q[0] || (rob_ix_out[0] ? rval1_out : rval2_out) !== 32'h66)
          $display("FAIL full_order got rob=%0d r1=%h r2=%h exp rob=%0d", rob_ix_out, rval1_out, rval2_out, exp_q[0]);
        else pass_cnt++;
        void'(exp_q.pop_front());
      end
    end
    check_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL full_timeout got remaining=%0d exp remaining=0", exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
    drain();
  endtask

`ifdef RS_FLUSH_EN
  task automatic test_flush();
    fu_ready_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_insert(RW'(k + 1), OW'(k), DW'(k), 1'b1, 3'd0, DW'(k), 1'b1, 3'd0);
      tick();
    end
    drive_idle();
    check_cnt++;
    if (rs_output_valid_out !== 1'b1 || free_count_out !== CW'(DEPTH - 3))
      $display("FAIL flush_setup got v=%b free=%0d exp v=1 free=%0d", rs_output_valid_out, free_count_out, DEPTH - 3);
    else pass_cnt++;
    flush_in = 1'b1;
    drive_insert(3'd7, 4'd7, 32'd7, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0);
    drive_cdb(3'd0, 32'd1);
    tick();
    drive_idle();
    check_cnt++;
    if (rs_output_valid_out !== 1'b0 || free_count_out !== CW'(DEPTH) || rs_free_for_input_out !== 1'b1)
      $display("FAIL flush_clear got v=%b free=%0d exp v=0 free=%0d", rs_output_valid_out, free_count_out, DEPTH);
    else pass_cnt++;
    drain();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      valid_input_in = ($urandom_range(0, 3) != 0);
      Q_i_in = RW'($urandom_range(0, 7));
      Q_j_in = RW'($urandom_range(0, 7));
      V_i_in = $urandom();
      V_j_in = $urandom();
      i_ready_in = ($urandom_range(0, 2) != 0);
      j_ready_in = ($urandom_range(0, 2) != 0);
      rob_ix_in = RW'($urandom_range(0, 7));
      opcode_in = OW'($urandom_range(0, 15));
      cdb_valid_in = ($urandom_range(0, 1) != 0);
      cdb_rob_ix_in = RW'($urandom_range(0, 7));
      cdb_value_in = $urandom();
      fu_ready_in = ($urandom_range(0, 3) != 0);
`ifdef RS_FLUSH_EN
      flush_in = ($urandom_range(0, 40) == 0);
`endif
      tick();
      check_cnt++;
      if (got_vec !== exp_vec()) $display("FAIL random cycle=%0d got=%h exp=%h", c, got_vec, exp_vec());
      else pass_cnt++;
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    fu_ready_in = 1'b0;
    drive_insert(3'd4, 4'd8, 32'hAA, 1'b1, 3'd0, 32'hBB, 1'b1, 3'd0);
    tick();
    drive_insert(3'd5, 4'd8, 32'hCC, 1'b0, 3'd1, 32'hDD, 1'b1, 3'd0);
    tick();
    drive_idle();
    #2;
    rst_in = 1'b1;
    #1;
    model_reset();
    check_cnt++;
    if (got_vec !== {1'b0, {DW{1'b0}}, {DW{1'b0}}, {OW{1'b0}}, {RW{1'b0}}, CW'(DEPTH), 1'b1})
      $display("FAIL async_reset got=%h exp_valid=0 data=0 free=%0d", got_vec, DEPTH);
    else pass_cnt++;
    @(negedge clk_in);
    rst_in = 1'b0;
    fu_ready_in = 1'b1;
    tick();
    check_cnt++;
    if (got_vec !== exp_vec()) $display("FAIL post_reset got=%h exp=%h", got_vec, exp_vec());
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_wakeup_order();
    test_bypass();
    test_backpressure();
    test_full_order();
`ifdef RS_FLUSH_EN
    test_flush();
`endif
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
